// File: rtl/or1200_event_pkg.sv
// Shared constants and helpers for the OR1200 event pulser and the event-status SPR logic.
//   EVT_MAX_SRC  : widest event-source vector supported
//   EVT_GAP_W    : width of the inter-pulse gap counter
//   evt_popcount : number of set bits in an EVT_MAX_SRC-wide vector
package or1200_event_pkg;

    localparam int unsigned EVT_MAX_SRC = 8;
    localparam int unsigned EVT_GAP_W   = 4;

    function automatic logic [3:0] evt_popcount(input logic [EVT_MAX_SRC-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < EVT_MAX_SRC; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/or1200_evt_popcount.sv
// Combinational population count of an NSRC-wide event vector.
//   vec : input bits (NSRC wide, 1..8)
//   cnt : number of set bits in vec (0..NSRC)
module or1200_evt_popcount
    import or1200_event_pkg::*;
#(
    parameter int unsigned NSRC = 4
) (
    input  logic [NSRC-1:0] vec,
    output logic [3:0]      cnt
);

    logic [EVT_MAX_SRC-1:0] padded;

    assign padded = EVT_MAX_SRC'(vec);
    assign cnt    = evt_popcount(padded);

endmodule

// File: rtl/or1200_event_pulser.sv
// Turns enabled rising edges on NSRC level-type event lines into a stream of single-cycle
// increment pulses for the downstream 4-bit event counter. Detected edges are queued in a
// saturating pending counter and drained at most one per cycle, spaced by GAP idle cycles.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   src_lvl  : raw event levels
//   src_en   : per-source edge enable
//   ovf_clr  : clears the sticky overflow flag (a coincident new overflow wins)
//   inc      : registered increment pulse
//   pending  : events queued but not yet pulsed
//   overflow : sticky, at least one event was dropped
//   busy     : pending != 0 or inc high (register-only path)
module or1200_event_pulser
    import or1200_event_pkg::*;
#(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned PEND_W = 4,
    parameter int unsigned GAP    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src_lvl,
    input  logic [NSRC-1:0]   src_en,
    input  logic              ovf_clr,
    output logic              inc,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic              busy
);

    // Four guard bits are enough for pending + up to 8 arrivals without wrapping.
    localparam int unsigned       SumW    = PEND_W + 4;
    localparam logic [SumW-1:0]   PendMax = SumW'((1 << PEND_W) - 1);
    localparam logic [EVT_GAP_W-1:0] GapLd = EVT_GAP_W'(GAP);

    logic [NSRC-1:0]      prev_q;
    logic [PEND_W-1:0]    pend_q, pend_d;
    logic                 ovf_q, ovf_d;
    logic                 inc_q;
    logic [EVT_GAP_W-1:0] gap_q, gap_d;

    logic [NSRC-1:0] rise;
    logic [3:0]      nrise;
    logic            fire;
    logic [SumW-1:0] sum;
    logic            sat;

    assign rise = src_lvl & ~prev_q & src_en;

    or1200_evt_popcount #(
        .NSRC (NSRC)
    ) u_popcount (
        .vec (rise),
        .cnt (nrise)
    );

    always_comb begin
        fire   = (pend_q != '0) && (gap_q == '0);
        // Arrivals and the drained event are netted in one step.
        sum    = SumW'(pend_q) + SumW'(nrise) - SumW'(fire);
        sat    = sum > PendMax;
        pend_d = sat ? PendMax[PEND_W-1:0] : sum[PEND_W-1:0];

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (sat) begin
            ovf_d = 1'b1;
        end

        gap_d = gap_q;
        if (fire) begin
            gap_d = GapLd;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Track levels during reset so lines already high at release are not events.
            prev_q <= src_lvl;
            pend_q <= '0;
            ovf_q  <= 1'b0;
            inc_q  <= 1'b0;
            gap_q  <= '0;
        end else begin
            prev_q <= src_lvl;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            inc_q  <= fire;
            gap_q  <= gap_d;
        end
    end

    assign inc      = inc_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;
    assign busy     = (pend_q != '0) || inc_q;

endmodule

// File: doc/or1200_event_pulser.md
Name: or1200_event_pulser

Overview:
- Upstream feeder for the 4-bit incremental event counter.
- Watches NSRC level-type event sources from the OR1200 crypto/DB datapath (e.g. engine-done, tag-mismatch) and detects enabled rising edges.
- Queues the detected edges in a saturating pending counter.
- Drains the queue as single-cycle increment pulses on `inc`, at most one per cycle and spaced by GAP idle cycles. `inc` wires directly to the counter's `in` port.

Parameters:
- NSRC, 4, number of event source lines (1..8).
- PEND_W, 4, width of the pending-event counter; maximum queue depth is 2^PEND_W-1.
- GAP, 0, idle cycles forced between consecutive `inc` pulses (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- src_lvl  input  NSRC  raw event levels, synchronous to clk.
- src_en  input  NSRC  per-source enable; a 0 masks that source's edges.
- ovf_clr  input  1  single-cycle clear of `overflow`.
- inc  output  1  registered increment pulse to the downstream counter.
- pending  output  PEND_W  events queued but not yet pulsed.
- overflow  output  1  sticky flag: at least one event was dropped.
- busy  output  1  pending != 0 or inc == 1.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high; the clock port is `clk` and the reset port is `rst`.
  - Reset values: inc=0, pending=0, overflow=0, gap_cnt=0.
  - During reset, prev_lvl <= src_lvl. Sources already high at reset release therefore produce no event.
- Edge detection:
  - rise = src_lvl & ~prev_lvl & src_en. prev_lvl <= src_lvl every non-reset cycle.
  - Raising src_en while the level is already high generates no event.
- Per-cycle arithmetic:
  - nrise = popcount(rise), range 0..NSRC.
  - fire = (pending != 0) && (gap_cnt == 0).
  - sum = pending + nrise - fire, computed in PEND_W+4 bits with no wrap.
- Pending update:
  - If sum > 2^PEND_W-1: pending <= 2^PEND_W-1 and overflow <= 1. Excess events are discarded.
  - Otherwise pending <= sum.
- Pulse generation:
  - inc <= fire. inc is high for exactly one cycle per fired event.
  - gap_cnt <= GAP when fire. Otherwise gap_cnt decrements toward 0, saturating at 0.
- Latency:
  - Source rising edge sampled at clock edge t: pending increments at t+1, and inc is high in the cycle following edge t+2 when the queue was empty and gap_cnt == 0.
  - With GAP=0, sustained throughput is 1 pulse/cycle.
- Simultaneous events:
  - Arrivals and a fire in the same cycle are netted. Example: pending=1, two rises, one fire -> pending=2.
  - ovf_clr together with a new saturation: set wins, overflow stays 1.
  - Several sources rising in one cycle each count as one event.
- Boundaries:
  - pending at maximum with fire and one rise: pending stays at maximum, no overflow.
  - pending at maximum with two rises and fire: overflow is set.
- Reset mid-operation: all queued events are discarded, inc drops the next cycle, and no partial pulse is produced.
- busy is combinational from registers only; it has no combinational path from any input.

Decomposition:
- Shared package or1200_event_pkg holds:
  - constant EVT_MAX_SRC = 8;
  - a popcount function sized for EVT_MAX_SRC;
  - the GAP counter width constant EVT_GAP_W = 4.
- One natural sub-module, or1200_evt_popcount: combinational NSRC -> 4-bit count, reused by the event-status SPR logic.
- Edge detection, the pending queue and the pulse/gap logic stay in the top module.

Test Plan:
- Reset release with src_lvl=4'b0101 held high -> no inc, pending=0 for 20 cycles.
- GAP=0, single rise on src[0] at edge t -> pending=1 after t+1, inc=1 for exactly one cycle after t+2, pending=0 afterwards; downstream counter reads 1.
- GAP=2, rises on src[0..3] in the same cycle -> pending=4, then 4 inc pulses each separated by 2 idle cycles; counter reads 4; busy falls with the last pulse.
- PEND_W=2, src[3:0] rise together twice on consecutive sample cycles -> pending saturates at 3, overflow=1; ovf_clr pulse clears overflow; ovf_clr coincident with a fresh saturation leaves overflow=1.
- src_en=4'b0010: rises on src[0] and src[1] -> only 1 event; raising src_en[0] while src[0] is high -> no event.
- Assert rst while pending=5 and inc is pulsing -> pending=0, inc=0 one cycle after the reset edge, no further pulses after deassertion.
